// File: rtl/microwave_pkg.sv
// Shared state encoding and default timing for the microwave controller.
package microwave_pkg;

  localparam int unsigned TickDivDefault    = 100;
  localparam int unsigned DoneCyclesDefault = 8;
  localparam int unsigned MaxDigits         = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high in the wrap cycle only.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  input  logic hold,
  input  logic sync_clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run;
  logic            wrap;

  assign run  = enable && !hold;
  assign wrap = (cnt_q == CntW'(TICK_DIV - 1));
  assign tick = run && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven sequencer: keypad digit entry, cook/pause/done control and
// registered strobes to an external BCD countdown timer.
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TickDivDefault,
  parameter int unsigned DONE_CYCLES = DoneCyclesDefault
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_loadn,
  output logic [3:0] timer_data,
  output logic       timer_clear,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned DoneW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [1:0]       digit_cnt_q, digit_cnt_d;
  logic [DoneW-1:0] done_cnt_q, done_cnt_d;
  logic             key_ok;
  logic             key_load;
  logic             to_idle;
  logic             tick;

  logic             timer_loadn_q;
  logic [3:0]       timer_data_q;
  logic             timer_clear_q;
  logic             timer_enable_q;
  logic             mag_on_q;
  logic             done_q;

  assign key_ok = key_valid && is_bcd(key_digit) && (digit_cnt_q < 2'(MaxDigits));

  // Priority order inside each state: stop, door open, timer_zero, start, key.
  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    done_cnt_d  = done_cnt_q;
    key_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!stop && key_ok) begin
          key_load = 1'b1;
          state_d  = StEntry;
        end
      end
      StEntry: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start && door_closed && !timer_zero) begin
          state_d = StCook;
        end else if (key_ok) begin
          key_load = 1'b1;
        end
      end
      StCook: begin
        if (stop || !door_closed) begin
          state_d = StPause;
        end else if (timer_zero) begin
          state_d    = StDone;
          done_cnt_d = '0;
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start && door_closed) begin
          state_d = StCook;
        end
      end
      StDone: begin
        if (stop || !door_closed) begin
          state_d = StIdle;
        end else if (done_cnt_q == DoneW'(DONE_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          done_cnt_d = done_cnt_q + DoneW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (key_load) begin
      digit_cnt_d = digit_cnt_q + 2'd1;
    end

    to_idle = (state_d == StIdle) && (state_q != StIdle);
    if (to_idle) begin
      digit_cnt_d = '0;
      done_cnt_d  = '0;
    end
  end

  // Prescaler only advances on cycles that stay in COOK, so it freezes on exit.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock      (clock),
    .clear      (clear),
    .enable     (state_q == StCook),
    .hold       (state_d != StCook),
    .sync_clear (to_idle),
    .tick       (tick)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q        <= StIdle;
      digit_cnt_q    <= '0;
      done_cnt_q     <= '0;
      timer_loadn_q  <= 1'b1;
      timer_data_q   <= '0;
      timer_clear_q  <= 1'b0;
      timer_enable_q <= 1'b0;
      mag_on_q       <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      digit_cnt_q    <= digit_cnt_d;
      done_cnt_q     <= done_cnt_d;
      timer_loadn_q  <= !key_load;
      if (key_load) begin
        timer_data_q <= key_digit;
      end
      timer_clear_q  <= to_idle;
      timer_enable_q <= tick;
      mag_on_q       <= (state_d == StCook);
      done_q         <= (state_d == StDone);
    end
  end

  assign timer_loadn  = timer_loadn_q;
  assign timer_data   = timer_data_q;
  assign timer_clear  = timer_clear_q;
  assign timer_enable = timer_enable_q;
  assign mag_on       = mag_on_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed scenarios for microwave_controller with TICK_DIV=4, DONE_CYCLES=8.
module tb_microwave_controller;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b0;
  logic       timer_loadn;
  logic [3:0] timer_data;
  logic       timer_clear;
  logic       timer_enable;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] SIdle = 3'd0, SEntry = 3'd1, SCook = 3'd2, SPause = 3'd3, SDone = 3'd4;

  microwave_controller #(
    .TICK_DIV    (4),
    .DONE_CYCLES (8)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .timer_loadn  (timer_loadn),
    .timer_data   (timer_data),
    .timer_clear  (timer_clear),
    .timer_enable (timer_enable),
    .mag_on       (mag_on),
    .done         (done),
    .state        (state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (state !== SIdle) begin bad++; $display("FAIL rst_state got=%0d want=%0d", state, SIdle); end
    total++; if (timer_loadn !== 1'b1) begin bad++; $display("FAIL rst_loadn got=%b want=1", timer_loadn); end
    total++; if (timer_data !== 4'd0) begin bad++; $display("FAIL rst_data got=%0d want=0", timer_data); end
    total++; if ({timer_clear, timer_enable, mag_on, done} !== 4'b0) begin
      bad++; $display("FAIL rst_outs got=%b want=0000", {timer_clear, timer_enable, mag_on, done});
    end
    clear = 1'b0;
    step();
    total++; if (state !== SIdle) begin bad++; $display("FAIL post_rst_state got=%0d want=%0d", state, SIdle); end
  endtask

  task automatic test_entry_cook();
    logic [3:0] keys [3];
    keys[0] = 4'd1; keys[1] = 4'd3; keys[2] = 4'd0;
    for (int k = 0; k < 3; k++) begin
      key_valid = 1'b1; key_digit = keys[k];
      step();
      total++; if (timer_loadn !== 1'b0 || timer_data !== keys[k]) begin
        bad++; $display("FAIL key_strobe%0d got=%b/%0d want=0/%0d", k, timer_loadn, timer_data, keys[k]);
      end
    end
    total++; if (state !== SEntry) begin bad++; $display("FAIL entry_state got=%0d want=%0d", state, SEntry); end
    key_valid = 1'b0;
    step();
    total++; if (timer_loadn !== 1'b1) begin bad++; $display("FAIL loadn_release got=%b want=1", timer_loadn); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (state !== SCook || mag_on !== 1'b1) begin
      bad++; $display("FAIL cook_enter got=%0d/%b want=%0d/1", state, mag_on, SCook);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      total++; if (timer_enable !== (i % 4 == 0)) begin
        bad++; $display("FAIL cook_tick%0d got=%b want=%b", i, timer_enable, (i % 4 == 0));
      end
      total++; if (mag_on !== 1'b1) begin bad++; $display("FAIL cook_mag%0d got=%b want=1", i, mag_on); end
    end
  endtask

  task automatic test_done();
    timer_zero = 1'b1;
    step();
    total++; if (state !== SDone || mag_on !== 1'b0 || done !== 1'b1 || timer_enable !== 1'b0) begin
      bad++; $display("FAIL done_enter got=%0d/%b/%b/%b want=%0d/0/1/0", state, mag_on, done, timer_enable, SDone);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      total++; if (done !== 1'b1 || state !== SDone) begin
        bad++; $display("FAIL done_hold%0d got=%b/%0d want=1/%0d", i, done, state, SDone);
      end
    end
    step();
    total++; if (state !== SIdle || done !== 1'b0 || timer_clear !== 1'b1) begin
      bad++; $display("FAIL done_exit got=%0d/%b/%b want=%0d/0/1", state, done, timer_clear, SIdle);
    end
    timer_zero = 1'b0;
    step();
    total++; if (timer_clear !== 1'b0) begin bad++; $display("FAIL done_clr_once got=%b want=0", timer_clear); end
  endtask

  task automatic test_pause_resume();
    key_valid = 1'b1; key_digit = 4'd2;
    step();
    key_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    door_closed = 1'b0;
    step();
    total++; if (state !== SPause || mag_on !== 1'b0) begin
      bad++; $display("FAIL pause_enter got=%0d/%b want=%0d/0", state, mag_on, SPause);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (timer_enable !== 1'b0 || state !== SPause) begin
        bad++; $display("FAIL pause_hold%0d got=%b/%0d want=0/%0d", i, timer_enable, state, SPause);
      end
    end
    door_closed = 1'b1;
    step();
    total++; if (state !== SPause) begin bad++; $display("FAIL pause_door_shut got=%0d want=%0d", state, SPause); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (state !== SCook || mag_on !== 1'b1 || timer_enable !== 1'b0) begin
      bad++; $display("FAIL resume got=%0d/%b/%b want=%0d/1/0", state, mag_on, timer_enable, SCook);
    end
    step();
    total++; if (timer_enable !== 1'b0) begin bad++; $display("FAIL resume_t1 got=%b want=0", timer_enable); end
    step();
    total++; if (timer_enable !== 1'b1) begin bad++; $display("FAIL resume_t2 got=%b want=1", timer_enable); end
    step();
    total++; if (timer_enable !== 1'b0) begin bad++; $display("FAIL resume_t3 got=%b want=0", timer_enable); end
  endtask

  task automatic test_stop_start_pause();
    stop = 1'b1;
    step();
    total++; if (state !== SPause) begin bad++; $display("FAIL stop_pause got=%0d want=%0d", state, SPause); end
    start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    total++; if (state !== SIdle || timer_clear !== 1'b1 || mag_on !== 1'b0) begin
      bad++; $display("FAIL stop_wins got=%0d/%b/%b want=%0d/1/0", state, timer_clear, mag_on, SIdle);
    end
    step();
    total++; if (timer_clear !== 1'b0) begin bad++; $display("FAIL stop_clr_once got=%b want=0", timer_clear); end
  endtask

  task automatic test_bad_keys();
    logic [3:0] keys [5];
    logic       strobe [5];
    keys[0] = 4'd5; keys[1] = 4'hA; keys[2] = 4'd1; keys[3] = 4'd2; keys[4] = 4'd3;
    strobe[0] = 1'b1; strobe[1] = 1'b0; strobe[2] = 1'b1; strobe[3] = 1'b1; strobe[4] = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (state !== SIdle) begin bad++; $display("FAIL idle_start got=%0d want=%0d", state, SIdle); end
    for (int k = 0; k < 5; k++) begin
      key_valid = 1'b1; key_digit = keys[k];
      step();
      total++; if (timer_loadn !== !strobe[k]) begin
        bad++; $display("FAIL badkey_loadn%0d got=%b want=%b", k, timer_loadn, !strobe[k]);
      end
      if (strobe[k]) begin
        total++; if (timer_data !== keys[k]) begin
          bad++; $display("FAIL badkey_data%0d got=%0d want=%0d", k, timer_data, keys[k]);
        end
      end
    end
    key_valid = 1'b0; door_closed = 1'b0; start = 1'b1;
    step();
    total++; if (state !== SEntry || mag_on !== 1'b0) begin
      bad++; $display("FAIL start_door_open got=%0d/%b want=%0d/0", state, mag_on, SEntry);
    end
    door_closed = 1'b1; timer_zero = 1'b1;
    step();
    total++; if (state !== SEntry) begin bad++; $display("FAIL start_tz got=%0d want=%0d", state, SEntry); end
    timer_zero = 1'b0; start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (state !== SIdle || timer_clear !== 1'b1) begin
      bad++; $display("FAIL entry_stop got=%0d/%b want=%0d/1", state, timer_clear, SIdle);
    end
  endtask

  task automatic test_reset_midcook();
    key_valid = 1'b1; key_digit = 4'd4;
    step();
    key_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    total++; if (mag_on !== 1'b1) begin bad++; $display("FAIL precook_mag got=%b want=1", mag_on); end
    #2;
    clear = 1'b1;
    #1;
    total++; if (mag_on !== 1'b0 || state !== SIdle) begin
      bad++; $display("FAIL async_clear got=%b/%0d want=0/%0d", mag_on, state, SIdle);
    end
    total++; if (timer_loadn !== 1'b1 || timer_data !== 4'd0 || {timer_clear, timer_enable, done} !== 3'b0) begin
      bad++; $display("FAIL async_outs got=%b/%0d/%b want=1/0/000", timer_loadn, timer_data,
                      {timer_clear, timer_enable, done});
    end
    step();
    clear = 1'b0;
    step();
    total++; if (state !== SIdle || mag_on !== 1'b0) begin
      bad++; $display("FAIL post_clear got=%0d/%b want=%0d/0", state, mag_on, SIdle);
    end
    key_valid = 1'b1; key_digit = 4'd7;
    step();
    key_valid = 1'b0;
    total++; if (timer_loadn !== 1'b0 || timer_data !== 4'd7 || state !== SEntry) begin
      bad++; $display("FAIL post_clear_key got=%b/%0d/%0d want=0/7/%0d", timer_loadn, timer_data, state, SEntry);
    end
  endtask

  initial begin
    test_reset();
    test_entry_cook();
    test_done();
    test_pause_resume();
    test_stop_start_pause();
    test_bad_keys();
    test_reset_midcook();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_controller.md
MICROWAVE_CONTROLLER -- requirements
Module: microwave_controller

Interface
REQ-001 Parameter TICK_DIV, default 100, gives clock cycles per 1-second tick (minimum 2).
REQ-002 Parameter DONE_CYCLES, default 8, gives cycles the done indication is held.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 clear  in  1  reset; asynchronous, active-high.
REQ-005 key_valid  in  1  one-cycle pulse, keypad digit present.
REQ-006 key_digit  in  4  BCD digit qualified by key_valid.
REQ-007 start  in  1  one-cycle start/resume pulse.
REQ-008 stop  in  1  one-cycle pause/cancel pulse.
REQ-009 door_closed  in  1  level; 1 = door closed.
REQ-010 timer_zero  in  1  level from the countdown timer; 1 = all digits zero.
REQ-011 timer_loadn  out  1  active-low digit-load strobe to the timer.
REQ-012 timer_data  out  4  digit shifted into the timer on the timer_loadn strobe.
REQ-013 timer_clear  out  1  active-high one-cycle timer clear pulse.
REQ-014 timer_enable  out  1  one-cycle decrement pulse to the timer.
REQ-015 mag_on  out  1  magnetron enable.
REQ-016 done  out  1  cook-complete indication.
REQ-017 state  out  3  current FSM state encoding, for debug/display.

Function
REQ-018 FSM states SHALL be IDLE, ENTRY, COOK, PAUSE, DONE; all outputs SHALL be registered.
REQ-019 IDLE/ENTRY: key_valid with key_digit<=9 and digit count<3 SHALL drive timer_loadn=0, timer_data=key_digit for exactly the next cycle, increment digit count, and move to/stay in ENTRY.
REQ-020 Digits >9, a 4th or later digit, and key_valid in COOK/PAUSE/DONE SHALL be ignored (no strobe).
REQ-021 start in ENTRY with door_closed=1 and timer_zero=0 SHALL enter COOK next cycle; otherwise start SHALL be ignored; start in IDLE SHALL be ignored.
REQ-022 COOK: mag_on=1; prescaler counts 0..TICK_DIV-1 and wraps; timer_enable SHALL pulse for one cycle on each wrap.
REQ-023 COOK: timer_zero=1 SHALL enter DONE next cycle with mag_on=0 and no further timer_enable.
REQ-024 COOK: door_closed=0 or stop SHALL enter PAUSE next cycle; prescaler SHALL hold its value in PAUSE.
REQ-025 PAUSE: start with door_closed=1 SHALL resume COOK with prescaler continuing from its held value; stop SHALL enter IDLE.
REQ-026 ENTRY: stop SHALL enter IDLE.
REQ-027 DONE: done=1 for DONE_CYCLES cycles, then IDLE; stop or door_closed=0 SHALL end DONE early and enter IDLE next cycle.
REQ-028 Every transition into IDLE (except from reset) SHALL pulse timer_clear for one cycle and zero digit count and prescaler.
REQ-029 Priority within a cycle: stop > door open > timer_zero > start > key_valid.
REQ-030 timer_loadn, timer_enable and timer_clear SHALL never be active in the same cycle.

Reset
REQ-031 clear=1 SHALL immediately force state=IDLE, prescaler=0, digit count=0, done counter=0.
REQ-032 During and after reset: timer_loadn=1, timer_data=0, timer_clear=0, timer_enable=0, mag_on=0, done=0.
REQ-033 Reset mid-COOK SHALL drop mag_on asynchronously; first post-reset cycle behaves as IDLE.

Structure
REQ-034 State encoding constants and TICK_DIV/DONE_CYCLES defaults SHALL live in shared package microwave_pkg.
REQ-035 The prescaler SHALL be a sub-module tick_prescaler (enable, hold, sync clear, one-cycle tick out).

Verification
REQ-036 Keys 1,3,0 then start, door closed, TICK_DIV=4 -> three loadn strobes with data 1,3,0; COOK; timer_enable every 4 cycles; mag_on=1.
REQ-037 In COOK assert timer_zero -> DONE next cycle, mag_on=0, done=1 for 8 cycles, then IDLE with one timer_clear pulse.
REQ-038 Open door mid-COOK at prescaler=2, close, start -> PAUSE, no timer_enable while open; first tick after resume 2 cycles later.
REQ-039 Keys 5,A,1,2,3 -> strobes only for 5,1,2; start with door open -> stays ENTRY.
REQ-040 stop and start same cycle in PAUSE -> IDLE, timer_clear pulse; clear asserted mid-COOK -> all outputs 0, timer_loadn=1, state IDLE.
